// File: rtl/axi_ram_pkg.sv
// Shared types and helpers for the AXI burst RAM.
// AXI_RAM_WRAP_BURST_EN enables WRAP burst support.
package axi_ram_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

`ifdef AXI_RAM_WRAP_BURST_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_t;

  typedef enum logic {
    R_IDLE,
    R_ACTIVE
  } r_state_t;

  // True when the burst can be served; WRAP needs a legal
  // length and a size-aligned start address.
  function automatic logic burst_legal(
    input logic [1:0] burst,
    input logic [7:0] len,
    input logic [2:0] size,
    input logic [2:0] max_size,
    input logic [7:0] addr_lo
  );
    logic ok;
    logic len_ok;
    logic aligned;
    ok      = 1'b0;
    len_ok  = (len == 8'd1) || (len == 8'd3) ||
              (len == 8'd7) || (len == 8'd15);
    aligned = (addr_lo & ((8'd1 << size) - 8'd1)) == 8'd0;
    if (size <= max_size) begin
      unique case (burst)
        BURST_FIXED: ok = 1'b1;
        BURST_INCR:  ok = 1'b1;
        BURST_WRAP:  ok = WRAP_EN && len_ok && aligned;
        default:     ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Next-beat address for FIXED / INCR / WRAP bursts.
// Wrap legality is checked elsewhere; this just does the math.
module axi_burst_addr_gen
  import axi_ram_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 12
) (
  input  logic [ADDRESS_WIDTH-1:0] i_addr,
  input  logic [2:0]               i_size,
  input  logic [7:0]               i_len,
  input  logic [1:0]               i_burst,
  output logic [ADDRESS_WIDTH-1:0] o_next
);

  localparam int AW = ADDRESS_WIDTH;

  logic [AW-1:0] w_step;
  logic [AW-1:0] w_inc;
  logic [AW-1:0] w_wmask;

  assign w_step  = AW'(1) << i_size;
  assign w_inc   = i_addr + w_step;
  assign w_wmask = ((AW'(i_len) + AW'(1)) << i_size) - AW'(1);

  // Select next address by burst type
  always_comb begin
    o_next = i_addr;
    unique case (i_burst)
      BURST_INCR: o_next = w_inc;
      BURST_WRAP: o_next = (i_addr & ~w_wmask) | (w_inc & w_wmask);
      default:    o_next = i_addr;
    endcase
  end

endmodule

// File: rtl/axi_burst_ram.sv
// AXI4 slave burst RAM, independent read and write channels.
// AXI_RAM_WRAP_BURST_EN enables WRAP burst support.
module axi_burst_ram
  import axi_ram_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int STROBE_WIDTH  = DATA_WIDTH / 8,
  parameter int ADDRESS_WIDTH = 12
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [ADDRESS_WIDTH-1:0] i_awaddr,
  input  logic [7:0]               i_awlen,
  input  logic [2:0]               i_awsize,
  input  logic [1:0]               i_awburst,
  input  logic                     i_awvalid,
  output logic                     o_awready,
  input  logic [DATA_WIDTH-1:0]    i_wdata,
  input  logic [STROBE_WIDTH-1:0]  i_wstrb,
  input  logic                     i_wlast,
  input  logic                     i_wvalid,
  output logic                     o_wready,
  output logic [1:0]               o_bresp,
  output logic                     o_bvalid,
  input  logic                     i_bready,
  input  logic [ADDRESS_WIDTH-1:0] i_araddr,
  input  logic [7:0]               i_arlen,
  input  logic [2:0]               i_arsize,
  input  logic [1:0]               i_arburst,
  input  logic                     i_arvalid,
  output logic                     o_arready,
  output logic [DATA_WIDTH-1:0]    o_rdata,
  output logic [1:0]               o_rresp,
  output logic                     o_rlast,
  output logic                     o_rvalid,
  input  logic                     i_rready
);

  localparam int AW    = ADDRESS_WIDTH;
  localparam int LSB   = $clog2(STROBE_WIDTH);
  localparam int DEPTH = 2 ** (AW - LSB);
  localparam logic [2:0] MAX_SIZE = 3'(LSB);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // ---------------- write channel ----------------
  w_state_t      r_wstate;
  w_state_t      w_wstate_nx;
  logic [AW-1:0] r_waddr;
  logic [2:0]    r_wsize;
  logic [7:0]    r_wlen;
  logic [1:0]    r_wburst;
  logic [8:0]    r_wrem;
  logic          r_wbad;
  logic [1:0]    r_bresp;
  logic [AW-1:0] w_wnext;
  logic          w_aw_hs;
  logic          w_w_hs;
  logic          w_b_hs;
  logic          w_aw_legal;
  logic          w_we;

  assign o_awready = (r_wstate == W_IDLE);
  assign o_wready  = (r_wstate == W_DATA);
  assign o_bvalid  = (r_wstate == W_RESP);
  assign o_bresp   = r_bresp;

  assign w_aw_hs = i_awvalid & o_awready;
  assign w_w_hs  = i_wvalid & o_wready;
  assign w_b_hs  = o_bvalid & i_bready;
  assign w_we    = w_w_hs & ~r_wbad & (r_wrem != 9'd0);

  assign w_aw_legal = burst_legal(i_awburst, i_awlen, i_awsize,
                                  MAX_SIZE, 8'(i_awaddr));

  axi_burst_addr_gen #(.ADDRESS_WIDTH(AW)) u_waddr (
    .i_addr  (r_waddr),
    .i_size  (r_wsize),
    .i_len   (r_wlen),
    .i_burst (r_wburst),
    .o_next  (w_wnext)
  );

  // Write FSM state register
  always_ff @(posedge aclk) begin
    if (!aresetn) r_wstate <= W_IDLE;
    else          r_wstate <= w_wstate_nx;
  end

  // Write FSM next-state
  always_comb begin
    w_wstate_nx = r_wstate;
    unique case (r_wstate)
      W_IDLE: if (w_aw_hs) w_wstate_nx = W_DATA;
      W_DATA: if (w_w_hs && i_wlast) w_wstate_nx = W_RESP;
      W_RESP: if (w_b_hs) w_wstate_nx = W_IDLE;
      default: w_wstate_nx = W_IDLE;
    endcase
  end

  // Write burst tracking and response generation
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_waddr  <= '0;
      r_wsize  <= '0;
      r_wlen   <= '0;
      r_wburst <= BURST_FIXED;
      r_wrem   <= '0;
      r_wbad   <= 1'b0;
      r_bresp  <= RESP_OKAY;
    end else begin
      if (w_aw_hs) begin
        r_waddr  <= i_awaddr;
        r_wsize  <= i_awsize;
        r_wlen   <= i_awlen;
        r_wburst <= i_awburst;
        r_wrem   <= {1'b0, i_awlen} + 9'd1;
        r_wbad   <= ~w_aw_legal;
      end
      if (w_w_hs) begin
        if (r_wrem != 9'd0) begin
          r_wrem  <= r_wrem - 9'd1;
          r_waddr <= w_wnext;
        end
        if (i_wlast) begin
          r_bresp <= (r_wbad || r_wrem != 9'd1) ?
                     RESP_SLVERR : RESP_OKAY;
        end
      end
    end
  end

  // Byte-lane RAM write; contents are never reset
  always_ff @(posedge aclk) begin
    for (int i = 0; i < STROBE_WIDTH; i++) begin
      if (w_we && i_wstrb[i]) begin
        r_mem[r_waddr[AW-1:LSB]][8*i +: 8] <= i_wdata[8*i +: 8];
      end
    end
  end

  // ---------------- read channel ----------------
  r_state_t      r_rstate;
  r_state_t      w_rstate_nx;
  logic [AW-1:0] r_raddr;
  logic [2:0]    r_rsize;
  logic [7:0]    r_rlen;
  logic [1:0]    r_rburst;
  logic [7:0]    r_rrem;
  logic          r_rbad;
  logic [AW-1:0] w_rcur;
  logic [2:0]    w_rsize;
  logic [7:0]    w_rlen;
  logic [1:0]    w_rburst;
  logic [AW-1:0] w_rnext;
  logic          w_ar_hs;
  logic          w_r_hs;
  logic          w_ar_legal;

  assign o_arready = (r_rstate == R_IDLE);
  assign o_rvalid  = (r_rstate == R_ACTIVE);

  assign w_ar_hs = i_arvalid & o_arready;
  assign w_r_hs  = o_rvalid & i_rready;

  assign w_ar_legal = burst_legal(i_arburst, i_arlen, i_arsize,
                                  MAX_SIZE, 8'(i_araddr));

  // While idle the generator looks at the incoming AR beat
  assign w_rcur   = o_arready ? i_araddr  : r_raddr;
  assign w_rsize  = o_arready ? i_arsize  : r_rsize;
  assign w_rlen   = o_arready ? i_arlen   : r_rlen;
  assign w_rburst = o_arready ? i_arburst : r_rburst;

  axi_burst_addr_gen #(.ADDRESS_WIDTH(AW)) u_raddr (
    .i_addr  (w_rcur),
    .i_size  (w_rsize),
    .i_len   (w_rlen),
    .i_burst (w_rburst),
    .o_next  (w_rnext)
  );

  // Read FSM state register
  always_ff @(posedge aclk) begin
    if (!aresetn) r_rstate <= R_IDLE;
    else          r_rstate <= w_rstate_nx;
  end

  // Read FSM next-state
  always_comb begin
    w_rstate_nx = r_rstate;
    unique case (r_rstate)
      R_IDLE:   if (w_ar_hs) w_rstate_nx = R_ACTIVE;
      R_ACTIVE: if (w_r_hs && o_rlast) w_rstate_nx = R_IDLE;
      default:  w_rstate_nx = R_IDLE;
    endcase
  end

  // Registered read beats, next beat loaded on each handshake
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_raddr  <= '0;
      r_rsize  <= '0;
      r_rlen   <= '0;
      r_rburst <= BURST_FIXED;
      r_rrem   <= '0;
      r_rbad   <= 1'b0;
      o_rdata  <= '0;
      o_rresp  <= RESP_OKAY;
      o_rlast  <= 1'b0;
    end else if (w_ar_hs) begin
      r_raddr  <= w_rnext;
      r_rsize  <= i_arsize;
      r_rlen   <= i_arlen;
      r_rburst <= i_arburst;
      r_rrem   <= i_arlen;
      r_rbad   <= ~w_ar_legal;
      o_rdata  <= w_ar_legal ? r_mem[i_araddr[AW-1:LSB]] : '0;
      o_rresp  <= w_ar_legal ? RESP_OKAY : RESP_SLVERR;
      o_rlast  <= (i_arlen == 8'd0);
    end else if (w_r_hs) begin
      if (o_rlast) begin
        o_rlast <= 1'b0;
      end else begin
        o_rdata <= r_rbad ? '0 : r_mem[r_raddr[AW-1:LSB]];
        r_raddr <= w_rnext;
        r_rrem  <= r_rrem - 8'd1;
        o_rlast <= (r_rrem == 8'd1);
      end
    end
  end

endmodule
